// File: rtl/ipu_pkg.sv
// Shared definitions for the grid input processing unit.
// Holds FSM encoding, grid geometry, key indices and cursor stepping.
package ipu_pkg;

    typedef logic state_t;

    localparam state_t IDLE    = 1'b0;
    localparam state_t PENDING = 1'b1;

    localparam int GRID_CELLS = 9;
    localparam int COORD_W    = 4;
    localparam int KEY_MOVE   = 0;
    localparam int KEY_SELECT = 1;

    // Next cursor cell, wrapping from the last cell back to 0.
    function automatic logic [COORD_W-1:0] next_cell(
        input logic [COORD_W-1:0] c
    );
        if (c == COORD_W'(GRID_CELLS - 1))
            return '0;
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/ipu_grid_input_debounce.sv
// Single-key conditioner: 2-flop synchronizer, debounce counter, press pulse.
// Ports: clk, rst, key_n (raw, active-low) -> press (1-cycle pulse on 1->0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Accept the new level; pulse only on the released->pressed edge,
                // registered alongside the stable update so the FSM sees it next cycle.
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipu_grid_input.sv
// Push-button to tic-tac-toe cell input unit with held, acknowledged interrupt.
// Ports: clk, rst, key_n[1:0] (move/select), int_ack -> ipu_int, grid_coord, cursor.
module ipu_grid_input
    import ipu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         key_n,
    input  logic               int_ack,
    output logic               ipu_int,
    output logic [COORD_W-1:0] grid_coord,
    output logic [COORD_W-1:0] cursor
);

    logic   move_ev;
    logic   sel_ev;
    state_t state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_move (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n[KEY_MOVE]),
        .press(move_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_select (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n[KEY_SELECT]),
        .press(sel_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ipu_int    <= 1'b0;
            grid_coord <= '0;
            cursor     <= '0;
        end else if (state == IDLE) begin
            // Select has priority and captures the pre-move cursor.
            if (sel_ev) begin
                grid_coord <= cursor;
                ipu_int    <= 1'b1;
                state      <= PENDING;
            end else if (move_ev) begin
                cursor <= next_cell(cursor);
            end
        end else begin
            // While pending, key events are dropped and outputs stay frozen.
            if (int_ack) begin
                ipu_int <= 1'b0;
                state   <= IDLE;
            end
        end
    end

endmodule
